// File: rtl/ram512_pkg.sv
// Shared definitions for the 512-entry RAM stream reader: default widths and FSM encoding.
package ram512_pkg;

    localparam int unsigned AWIDTH_DEF = 9;
    localparam int unsigned DWIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry output buffer. When empty, the incoming word is presented at dout in the
// same cycle, so a beat can be pushed and popped together without ever being stored.
module skid_fifo2 #(
    parameter int unsigned DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DWIDTH-1:0] din,
    input  logic              pop,
    output logic [DWIDTH-1:0] dout,
    output logic [1:0]        count
);

    logic [DWIDTH-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic              bypass;
    logic              store;
    logic              take;

    assign bypass = (count == 2'd0);
    assign store  = push & ~(bypass & pop);
    assign take   = pop & ~bypass;

    assign dout = bypass ? (push ? din : '0) : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (store) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (take) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(store) - 2'(take);
        end
    end

endmodule

// File: rtl/ram_stream_reader.sv
// Burst reader: issues sequential RAM reads from start_addr and streams the returned words
// out on a valid/ready port, never requesting more data than the 2-entry buffer can hold.
module ram_stream_reader
    import ram512_pkg::*;
#(
    parameter int unsigned AWIDTH = AWIDTH_DEF,
    parameter int unsigned DWIDTH = DWIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AWIDTH-1:0] start_addr,
    input  logic [AWIDTH:0]   length,
    output logic              busy,
    output logic              done,
    output logic [AWIDTH-1:0] mem_addr,
    output logic              mem_re,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_last
);

    localparam int unsigned LW = AWIDTH + 1;

    rd_state_e     state;
    rd_state_e     state_nxt;
    logic [LW-1:0] remaining;
    logic [LW-1:0] len_q;
    logic [LW-1:0] beat_cnt;
    logic          rd_pending;
    logic [1:0]    fifo_count;
    logic [2:0]    credit;
    logic          accept;
    logic          issue;
    logic          pop;
    logic          last_hs;
    logic          done_nxt;

    skid_fifo2 #(.DWIDTH(DWIDTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rd_pending),
        .din   (mem_rdata),
        .pop   (pop),
        .dout  (m_data),
        .count (fifo_count)
    );

    assign busy    = (state != ST_IDLE);
    assign accept  = start & (state == ST_IDLE);
    assign m_valid = (fifo_count != 2'd0) | rd_pending;
    assign m_last  = m_valid & (beat_cnt == len_q - LW'(1));
    assign pop     = m_valid & m_ready;
    assign last_hs = pop & m_last;

    // Buffer slots already claimed: stored words plus reads still on their way back.
    assign credit = 3'(fifo_count) + 3'(rd_pending) + 3'(mem_re) - 3'(pop);
    assign issue  = (state == ST_READ) & (remaining != '0) & (credit < 3'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if ((remaining == '0) || (issue && (remaining == LW'(1)))) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (last_hs) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Read issue, address walk and beat counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_re     <= 1'b0;
            mem_addr   <= '0;
            remaining  <= '0;
            len_q      <= '0;
            beat_cnt   <= '0;
            rd_pending <= 1'b0;
            done       <= 1'b0;
        end else begin
            done       <= done_nxt;
            rd_pending <= mem_re;
            if (pop) begin
                beat_cnt <= beat_cnt + LW'(1);
            end
            if (accept && (length != '0)) begin
                mem_re    <= 1'b1;
                mem_addr  <= start_addr;
                remaining <= length - LW'(1);
                len_q     <= length;
                beat_cnt  <= '0;
            end else begin
                mem_re <= issue;
                if (issue) begin
                    mem_addr  <= mem_addr + AWIDTH'(1);
                    remaining <= remaining - LW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader: a producer turns accepted starts into expected
// addresses/beats, a monitor checks every read, beat, done and busy against them.
module tb_ram_stream_reader;

    localparam int unsigned AW    = 9;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 512;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic          mem_re;
    logic [DW-1:0] mem_rdata = '0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [DW-1:0] m_data;
    logic          m_last;

    ram_stream_reader #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) if (mem_re) mem_rdata <= ram[mem_addr];

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic          first;
        int            cyc;
    } beat_t;

    beat_t         exp_q[$];
    logic [AW-1:0] addr_q[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            opened_cnt = 0;
    int            closed_cnt = 0;
    int            hs_total = 0;
    logic          zl_flag = 1'b0;
    int            ready_mode = 0;
    int            pat_idx = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready: held high, the 1,0,0,1 pattern, or random.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1: begin
                m_ready = ((pat_idx % 4) == 0) || ((pat_idx % 4) == 3);
                pat_idx++;
            end
            2: m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b1;
        endcase
    end

    // Producer: a start is taken only when no burst is open; expand it into the reference stream.
    always @(negedge clk) begin : producer
        logic [AW-1:0] a;
        if (!rst_n) begin
            exp_q.delete();
            addr_q.delete();
            opened_cnt <= 0;
            zl_flag    <= 1'b0;
        end else begin
            zl_flag <= 1'b0;
            if (start && (opened_cnt == closed_cnt)) begin
                if (length == '0) begin
                    zl_flag <= 1'b1;
                end else begin
                    opened_cnt <= opened_cnt + 1;
                    for (int k = 0; k < int'(length); k++) begin
                        a = start_addr + AW'(k);
                        addr_q.push_back(a);
                        exp_q.push_back('{data: ram[a], last: (k == int'(length) - 1),
                                          first: (k == 0), cyc: cyc + 2});
                    end
                end
            end
        end
    end

    // Monitor: compares everything the DUT presents against the queues.
    always @(negedge clk) begin : monitor
        static logic          last_prev = 1'b0;
        static logic          stall_prev = 1'b0;
        static logic          hs_prev = 1'b0;
        static logic          first_chk = 1'b0;
        static logic [DW-1:0] pd = '0;
        static logic          pl = 1'b0;
        beat_t                e;
        logic [AW-1:0]        ea;
        logic                 hs_last;
        if (!rst_n) begin
            chk("reset_outputs", 32'({busy, done, mem_re, m_valid, m_last, mem_addr, m_data}), 32'd0);
            closed_cnt <= 0;
            last_prev  = 1'b0;
            stall_prev = 1'b0;
            hs_prev    = 1'b0;
            first_chk  = 1'b0;
        end else begin
            hs_last = 1'b0;
            chk("done", 32'(done), 32'(last_prev | zl_flag));
            chk("busy", 32'(busy), 32'(opened_cnt != closed_cnt));
            if (mem_re) begin
                if (addr_q.size() == 0) begin
                    chk("unexpected_mem_re", 32'(mem_addr), 32'hFFFF_FFFF);
                end else begin
                    ea = addr_q.pop_front();
                    chk("mem_addr", 32'(mem_addr), 32'(ea));
                end
            end
            if (stall_prev) begin
                chk("stall_stable", 32'({m_valid, m_last, m_data}), 32'({1'b1, pl, pd}));
            end
            if (hs_prev && !last_prev && m_ready) begin
                chk("back_to_back_valid", 32'(m_valid), 32'd1);
            end
            if (m_valid && (exp_q.size() > 0) && exp_q[0].first && !first_chk) begin
                chk("first_valid_cycle", 32'(cyc), 32'(exp_q[0].cyc));
                first_chk = 1'b1;
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'(m_data), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", 32'({m_last, m_data}), 32'({e.last, e.data}));
                    hs_last = e.last;
                    if (e.last) closed_cnt <= closed_cnt + 1;
                end
                first_chk = 1'b0;
                hs_total++;
            end
            last_prev  = hs_last;
            hs_prev    = m_valid && m_ready;
            stall_prev = m_valid && !m_ready;
            pd         = m_data;
            pl         = m_last;
        end
    end

    task automatic do_start(input logic [AW-1:0] addr, input logic [AW:0] len);
        @(posedge clk);
        #1;
        start      = 1'b1;
        start_addr = addr;
        length     = len;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        @(posedge clk);
        while (!((opened_cnt == closed_cnt) && (exp_q.size() == 0)) && (n < max_cyc)) begin
            @(posedge clk);
            n++;
        end
        if (n >= max_cyc) begin
            errors++;
            $display("FAIL burst_timeout: burst still open after %0d cycles, %0d beats pending", n, exp_q.size());
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic run_burst(input logic [AW-1:0] addr, input logic [AW:0] len);
        do_start(addr, len);
        wait_idle(3000);
    endtask

    initial begin : stim
        int base;
        int n;
        for (int i = 0; i < int'(DEPTH); i++) ram[i] = DW'(i);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        ready_mode = 0;
        run_burst(AW'(10), 10'd4);
        run_burst(AW'(510), 10'd4);

        ready_mode = 1;
        pat_idx    = 0;
        run_burst(AW'(5), 10'd8);
        ready_mode = 0;

        run_burst(AW'(7), 10'd0);

        // Second start one cycle after an accepted one must be ignored.
        @(posedge clk);
        #1;
        start = 1'b1; start_addr = AW'(20); length = 10'd4;
        @(posedge clk);
        #1;
        start_addr = AW'(100); length = 10'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle(200);

        run_burst(AW'(37), 10'd512);

        // Reset after the third beat of an 8-beat burst, then a fresh burst.
        do_start(AW'(200), 10'd8);
        base = hs_total;
        n = 0;
        while ((hs_total < base + 3) && (n < 200)) begin
            @(posedge clk);
            n++;
        end
        if (n >= 200) begin
            errors++;
            $display("FAIL reset_wait: only %0d beats seen", hs_total - base);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        run_burst(AW'(300), 10'd6);

        ready_mode = 2;
        for (int i = 0; i < int'(DEPTH); i++) ram[i] = DW'($urandom);
        for (int t = 0; t < 25; t++) begin
            logic [AW:0] len;
            len = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom_range(1, 40));
            run_burst(AW'($urandom_range(0, DEPTH - 1)), len);
        end
        ready_mode = 1;
        run_burst(AW'(500), 10'd30);

        chk("leftover_beats", 32'(exp_q.size()), 32'd0);
        chk("leftover_addrs", 32'(addr_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
